// File: rtl/data_mem_ctrl_pkg.sv
// Shared constants, FSM state type and access-size helpers for the MEM-stage
// data-memory controller.
package data_mem_ctrl_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    localparam int unsigned MEM_LATENCY_DEFAULT = 2;

    typedef enum logic [1:0] {
        MEM_ST_IDLE = 2'd0,
        MEM_ST_BUSY = 2'd1,
        MEM_ST_DONE = 2'd2
    } mem_state_t;

    // Undefined funct3 codes report as misaligned so they never reach the RAM.
    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off,
                                        input logic wr);
        logic ok;
        ok = 1'b0;
        if (wr) begin
            case (f3)
                FUNCT3_SB: ok = 1'b1;
                FUNCT3_SH: ok = ~off[0];
                FUNCT3_SW: ok = (off == 2'b00);
                default:   ok = 1'b0;
            endcase
        end else begin
            case (f3)
                FUNCT3_LB, FUNCT3_LBU: ok = 1'b1;
                FUNCT3_LH, FUNCT3_LHU: ok = ~off[0];
                FUNCT3_LW:             ok = (off == 2'b00);
                default:               ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the low byte/half across the word; byte enables pick the lane.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            FUNCT3_LB:  r = {{24{b[7]}}, b};
            FUNCT3_LBU: r = {24'h0, b};
            FUNCT3_LH:  r = {{16{h[15]}}, h};
            FUNCT3_LHU: r = {16'h0, h};
            default:    r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// MEM-stage request/response bundle between the pipeline (master) and the
// data-memory controller (slave).
interface data_mem_ctrl_if;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [2:0]  Funct3_i;
    logic [31:0] Addr_i;
    logic [31:0] WriteData_i;
    logic [31:0] ReadData_o;
    logic        Stall_o;
    logic        Misalign_o;

    modport master (
        output MemRead_i, MemWrite_i, Funct3_i, Addr_i, WriteData_i,
        input  ReadData_o, Stall_o, Misalign_o
    );

    modport slave (
        input  MemRead_i, MemWrite_i, Funct3_i, Addr_i, WriteData_i,
        output ReadData_o, Stall_o, Misalign_o
    );
endinterface

// File: rtl/data_mem_ctrl_data_ram.sv
// Single-port 32-bit word RAM with byte-enable writes and a registered read port.
module data_ram #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [3:0]            be_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Only the read register is reset; array contents are left alone.
    always_ff @(posedge clk_i) begin
        if (rst_i)     rdata_o <= '0;
        else if (re_i) rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory controller: IDLE/BUSY/DONE sequencer with fixed wait
// latency, stall generation, alignment check and load extension.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = MEM_LATENCY_DEFAULT
) (
    input  logic           clk_i,
    input  logic           rst_i,
    data_mem_ctrl_if.slave bus
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    mem_state_t            state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] req_word;
    logic [1:0]            req_off;
    logic [2:0]            req_f3;
    logic                  req_wr;
    logic [31:0]           req_wdata;
    logic [2:0]            rd_f3;
    logic [1:0]            rd_off;

    logic        req;
    logic        aligned;
    logic        complete;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^bus.Addr_i[31:ADDR_WIDTH+2];

    always_comb begin
        req      = bus.MemRead_i | bus.MemWrite_i;
        aligned  = is_aligned(bus.Funct3_i, bus.Addr_i[1:0], bus.MemWrite_i);
        complete = (state == MEM_ST_BUSY) && (cnt == '0) && !rst_i;
        ram_we   = complete & req_wr;
        ram_re   = complete & ~req_wr;
        bus.Stall_o    = (state == MEM_ST_BUSY) || ((state == MEM_ST_IDLE) && req && aligned);
        bus.Misalign_o = (state == MEM_ST_IDLE) && req && !aligned;
    end

    data_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_data_ram (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (ram_we),
        .re_i   (ram_re),
        .be_i   (byte_en(req_f3, req_off)),
        .addr_i (req_word),
        .wdata_i(store_lanes(req_f3, req_wdata)),
        .rdata_o(ram_rdata)
    );

    // The RAM read register is the ReadData_o storage; rd_f3/rd_off track the
    // last completed load so the extended value holds across later requests.
    assign bus.ReadData_o = load_extend(rd_f3, rd_off, ram_rdata);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= MEM_ST_IDLE;
            cnt       <= '0;
            req_word  <= '0;
            req_off   <= '0;
            req_f3    <= '0;
            req_wr    <= 1'b0;
            req_wdata <= '0;
            rd_f3     <= FUNCT3_LW;
            rd_off    <= '0;
        end else begin
            case (state)
                MEM_ST_IDLE: begin
                    if (req && aligned) begin
                        req_word  <= bus.Addr_i[ADDR_WIDTH+1:2];
                        req_off   <= bus.Addr_i[1:0];
                        req_f3    <= bus.Funct3_i;
                        req_wr    <= bus.MemWrite_i;
                        req_wdata <= bus.WriteData_i;
                        cnt       <= CNT_INIT;
                        state     <= MEM_ST_BUSY;
                    end
                end
                MEM_ST_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= MEM_ST_DONE;
                        if (!req_wr) begin
                            rd_f3  <= req_f3;
                            rd_off <= req_off;
                        end
                    end
                end
                MEM_ST_DONE: state <= MEM_ST_IDLE;
                default:     state <= MEM_ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed vector table, reset-abort
// sequence and randomized accesses against a byte-level memory model.
module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    localparam int unsigned AW  = 10;
    localparam int unsigned LAT = 2;
    localparam int unsigned NV  = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_ctrl_if bus ();

    data_mem_ctrl #(
        .ADDR_WIDTH(AW),
        .LATENCY   (LAT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [0:(1 << AW) - 1];
    logic [31:0] model_rd;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        mis;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic int acc_size(input logic wr, input logic [2:0] f3);
        int sz;
        if (wr) sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        else    sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 :
                     (f3 == 3'd2) ? 4 : 0;
        return sz;
    endfunction

    function automatic logic model_misaligned(input logic wr, input logic [2:0] f3,
                                              input logic [31:0] addr);
        int sz;
        sz = acc_size(wr, f3);
        return (sz == 0) || ((addr % sz) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        logic [31:0] v;
        sz = acc_size(1'b0, f3);
        v  = model_mem[(addr >> 2) % (1 << AW)] >> (8 * (addr % 4));
        if (sz == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata);
        int sz, idx, pos;
        logic [31:0] w, b;
        sz  = acc_size(1'b1, f3);
        idx = int'((addr >> 2) % (1 << AW));
        w   = model_mem[idx];
        for (int i = 0; i < sz; i++) begin
            b   = (wdata >> (8 * i)) & 32'hFF;
            pos = 8 * (int'(addr % 4) + i);
            w   = (w & ~(32'hFF << pos)) | (b << pos);
        end
        model_mem[idx] = w;
    endtask

    task automatic clear_inputs();
        bus.MemRead_i   = 1'b0;
        bus.MemWrite_i  = 1'b0;
        bus.Funct3_i    = 3'd0;
        bus.Addr_i      = 32'd0;
        bus.WriteData_i = 32'd0;
    endtask

    // One request starting at the next IDLE cycle; junk is driven during BUSY.
    task automatic do_access(input string name, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rd,
                             input logic exp_mis);
        int stall_cycles;
        @(negedge clk);
        bus.MemRead_i   = rd;
        bus.MemWrite_i  = wr;
        bus.Funct3_i    = f3;
        bus.Addr_i      = addr;
        bus.WriteData_i = wdata;
        #1;
        check($sformatf("%s misalign", name), 32'(bus.Misalign_o), 32'(exp_mis));
        check($sformatf("%s stall_T", name), 32'(bus.Stall_o), 32'(!exp_mis));
        if (exp_mis) begin
            @(negedge clk);
            clear_inputs();
            #1;
            check($sformatf("%s rdata_held", name), bus.ReadData_o, exp_rd);
            check($sformatf("%s stall_after", name), 32'(bus.Stall_o), 32'd0);
            return;
        end
        stall_cycles = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.MemRead_i   = 1'($urandom);
            bus.MemWrite_i  = 1'($urandom);
            bus.Funct3_i    = 3'($urandom);
            bus.Addr_i      = $urandom;
            bus.WriteData_i = $urandom;
            #1;
            if (!bus.Stall_o) break;
            stall_cycles++;
        end
        check($sformatf("%s stall_len", name), 32'(stall_cycles), 32'(LAT + 1));
        check($sformatf("%s rdata", name), bus.ReadData_o, exp_rd);
        clear_inputs();
        if (wr) model_store(f3, addr, wdata);
        else    model_rd = model_load(f3, addr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_rd, r_wr, r_mis;
        logic [2:0]  r_f3;
        logic [31:0] r_addr, r_wd, r_exp;

        vecs[0]  = '{1'b0, 1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'd2, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'd0, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'd4, 32'h13,   32'h0,        32'h000000DE, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'd1, 32'h12,   32'h0,        32'hFFFFDEAD, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'd5, 32'h10,   32'h0,        32'h0000BEEF, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'd0, 32'h11,   32'hAAAAAA55, 32'h0000BEEF, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'd2, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'd2, 32'h12,   32'h0,        32'hDEAD55EF, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 3'd1, 32'h11,   32'h0000FFFF, 32'hDEAD55EF, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 3'd3, 32'h10,   32'h0,        32'hDEAD55EF, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 3'd4, 32'h10,   32'h11111111, 32'hDEAD55EF, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 3'd2, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 3'd2, 32'h1010, 32'h0,        32'hDEAD55EF, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 3'd2, 32'h10,   32'hCAFEF00D, 32'hDEAD55EF, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 3'd2, 32'h10,   32'h0,        32'hCAFEF00D, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 3'd1, 32'h12,   32'h99991234, 32'hCAFEF00D, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 3'd5, 32'h12,   32'h0,        32'h00001234, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 3'd0, 32'h10,   32'h0,        32'h0000000D, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 3'd2, 32'h20,   32'h0BADCAFE, 32'h0000000D, 1'b0};

        rst = 1'b1;
        clear_inputs();
        model_rd = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset rdata", bus.ReadData_o, 32'h0);
        check("reset stall", 32'(bus.Stall_o), 32'd0);
        check("reset misalign", 32'(bus.Misalign_o), 32'd0);

        for (int i = 0; i < int'(NV); i++) begin
            do_access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].f3,
                      vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].mis);
        end

        // Reset in the second BUSY cycle, which is also the completing edge.
        @(negedge clk);
        bus.MemWrite_i  = 1'b1;
        bus.Funct3_i    = 3'd2;
        bus.Addr_i      = 32'h20;
        bus.WriteData_i = 32'h12345678;
        #1;
        check("abort stall_T", 32'(bus.Stall_o), 32'd1);
        @(negedge clk);
        clear_inputs();
        #1;
        check("abort stall_busy", 32'(bus.Stall_o), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort stall_idle", 32'(bus.Stall_o), 32'd0);
        check("abort rdata", bus.ReadData_o, 32'h0);
        model_rd = 32'h0;
        do_access("abort lw", 1'b1, 1'b0, 3'd2, 32'h20, 32'h0, 32'h0BADCAFE, 1'b0);

        for (int w = 16; w < 32; w++) begin
            r_wd = $urandom;
            do_access($sformatf("init%0d", w), 1'b0, 1'b1, 3'd2, 32'(w * 4), r_wd, model_rd, 1'b0);
        end

        for (int n = 0; n < 200; n++) begin
            r_rd   = 1'($urandom);
            r_wr   = 1'($urandom);
            if (!r_rd && !r_wr) r_rd = 1'b1;
            r_f3   = 3'($urandom_range(0, 7));
            r_addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(16, 31) * 4)
                     | 32'($urandom_range(0, 3));
            r_wd   = $urandom;
            r_mis  = model_misaligned(r_wr, r_f3, r_addr);
            r_exp  = (!r_mis && !r_wr) ? model_load(r_f3, r_addr) : model_rd;
            do_access($sformatf("rnd%0d", n), r_rd, r_wr, r_f3, r_addr, r_wd, r_exp, r_mis);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory responder for the MEM stage. It consumes the `MemRead`/`MemWrite` requests that the main decoder raises for LOAD/STORE opcodes and performs the access on a single-port word RAM with a configurable wait latency. It stalls the pipeline through `Stall_o` until the access completes, handles byte/half/word sizing with sign or zero extension, and flags misaligned requests.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits, giving 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 2: wait cycles before an access completes. Legal range 1..15.

Ports:
- `clk_i`  in  1: single clock. All state updates on the rising edge.
- `rst_i`  in  1: synchronous, active-high reset.
- `MemRead_i`  in  1: load request from the MEM-stage pipeline register.
- `MemWrite_i`  in  1: store request.
- `Funct3_i`  in  3: access size and sign. 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu for loads. 000 sb, 001 sh, 010 sw for stores.
- `Addr_i`  in  32: byte address, i.e. the ALU result.
- `WriteData_i`  in  32: store data from rs2. Low byte/half is used for sb/sh.
- `ReadData_o`  out  32: extended load result, registered.
- `Stall_o`  out  1: freezes PC and IF/ID, ID/EX, EX/MEM while high.
- `Misalign_o`  out  1: request is misaligned. Combinational, valid in IDLE.

## Operation
- States: IDLE, BUSY, DONE. Encodings live in `Const.v`.
- `req` = `MemRead_i | MemWrite_i`. If both are high, the write wins and the read is ignored.
- Alignment rules:
  - lw/sw need `Addr_i[1:0]==0`.
  - lh/lhu/sh need `Addr_i[0]==0`.
  - Byte accesses are always aligned.
  - Undefined funct3 values are treated as misaligned.
- IDLE, `req` and aligned:
  - `Stall_o`=1 combinationally.
  - Latch addr, data, funct3, rw into request registers.
  - Load `cnt`=LATENCY-1 and go to BUSY.
- IDLE, `req` and misaligned:
  - `Misalign_o`=1, `Stall_o`=0.
  - No RAM write; `ReadData_o` is unchanged.
  - The pipeline advances.
- BUSY:
  - `Stall_o`=1.
  - When `cnt`≠0, decrement `cnt`.
  - When `cnt`==0, perform the RAM access at this edge and go to DONE.
    - Write: byte-enables from `addr[1:0]` and size; only enabled bytes change.
    - Read: select the byte/half by `addr[1:0]`, sign-extend (lb/lh) or zero-extend (lbu/lhu), and register into `ReadData_o`.
- DONE:
  - `Stall_o`=0, so the pipeline advances at the end of this cycle.
  - Next state is IDLE, unconditionally.
  - Requests are not sampled in DONE. The held request is the one just served.
- Addressing: word index is `Addr_i[ADDR_WIDTH+1:2]`. Upper bits are ignored, so addresses wrap modulo RAM size.
- `ReadData_o` holds its value until the next completed read. Writes do not disturb it.

## Timing
- Reset values:
  - State IDLE, `cnt`=0, `ReadData_o`=0.
  - `Stall_o`=0 and `Misalign_o`=0 when no request is present.
  - RAM contents are not reset.
- Request first visible in cycle T: `Stall_o` is high in cycles T..T+LATENCY.
- DONE is cycle T+LATENCY+1. `ReadData_o` is valid there and the pipeline captures it at that edge.
- Throughput: one access per LATENCY+2 cycles. Back-to-back requests each pay the full latency.
- Reset asserted in BUSY: the access is aborted, no RAM write occurs, and state is IDLE next cycle.
- Reset asserted in the completing edge (BUSY with `cnt`==0): reset wins, and there is no write and no `ReadData_o` update.
- Request inputs may change during BUSY without effect, because the request registers are used.

## Structure
- `Const.v` additions:
  - `FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW`.
  - `MEM_ST_IDLE/BUSY/DONE`.
  - `MEM_LATENCY_DEFAULT`.
- Sub-module `data_ram`: synchronous single-port RAM, `ADDR_WIDTH` word address, 32-bit data, 4-bit byte-enable write, registered read.
  - Issue the `data_ram` read at the BUSY→DONE edge so that no extra cycle is added.
- FSM, counter, alignment check and load extension live in `data_mem_ctrl`.

## Test plan
- Reset, then sw 0xDEADBEEF @0x10 with LATENCY=2 → `Stall_o` high 3 cycles. Then lw @0x10 → `ReadData_o`=0xDEADBEEF in its DONE cycle.
- After that word: lb @0x13 → 0xFFFFFFDE; lbu @0x13 → 0x000000DE; lh @0x12 → 0xFFFFDEAD; lhu @0x10 → 0x0000BEEF.
- sb 0x55 @0x11, then lw @0x10 → 0xDEAD55EF. Other bytes are untouched.
- lw @0x12 (misaligned) → `Misalign_o`=1 and `Stall_o`=0 that cycle. The RAM and `ReadData_o` are unchanged.
- sw 0x12345678 @0x20, with `rst_i` pulsed in the second BUSY cycle → returns to IDLE. A later lw @0x20 returns the prior contents, not 0x12345678.
- Address 0x1010 with ADDR_WIDTH=10 → aliases to 0x10. Also, both `MemRead_i` and `MemWrite_i` high → a write is performed.
